mux2x1: RTL and testbench
=========================

MUX2X1 -- requirements
Module: mux2x1

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of in0, in1 and out (legal range 1..64).
REQ-002 Parameter OUT_REG, default 1, SHALL select a registered output (1) or a purely combinational output (0).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in0, input, WIDTH bits: data selected when sel=0.
REQ-006 Port in1, input, WIDTH bits: data selected when sel=1.
REQ-007 Port sel, input, 1 bit: select line.
REQ-008 Port out, output, WIDTH bits: selected data.
REQ-009 Port out_valid, output, 1 bit: high when out holds a selection made after reset was released.

Function
REQ-010 The selection SHALL be: next value = in1 when sel=1, otherwise in0, for all WIDTH bits.
REQ-011 With OUT_REG=1, out SHALL equal the selection sampled at the previous rising clk edge (latency 1 cycle).
REQ-012 With OUT_REG=1, a change on in0, in1 or sel SHALL NOT affect out before the next rising edge.
REQ-013 With OUT_REG=0, out SHALL follow the selection combinationally (latency 0), ignore clk and rst, and hold out_valid constantly 1.
REQ-014 A change of the unselected input SHALL never change out.
REQ-015 Changing sel and the newly selected input in the same cycle SHALL yield that input's new value at the next edge.
REQ-016 sel of X/Z is an illegal input; the design SHALL drive out to in0 in synthesis, and simulation behaviour is unspecified.
REQ-017 out_valid (OUT_REG=1) SHALL be 0 during reset and SHALL rise at the first rising edge with rst=0, then stay 1.
REQ-018 No arithmetic SHALL be performed; out is a bitwise copy of the chosen input with no extension or truncation.

Reset
REQ-019 With rst=1 at a rising edge (OUT_REG=1), out SHALL become all-zeros and out_valid SHALL become 0.
REQ-020 Reset SHALL take priority over selection at the same edge.
REQ-021 Asserting rst mid-operation SHALL clear out at the next edge, and selection SHALL resume on the first edge after deassertion.
REQ-022 Reset SHALL be synchronous; no asynchronous path from rst to out is permitted.

Structure
REQ-023 The default WIDTH constant SHALL live in the shared package used by the datapath blocks.
REQ-024 One sub-module, mux2x1_sel (combinational WIDTH-bit 2:1 select), SHALL be natural; mux2x1 wraps it with the optional output register and the valid flag.
REQ-025 The design SHALL contain no latches, and a single always block SHALL hold all registers.

Verification
REQ-026 Reset scenario: rst=1 for 2 cycles with in0=8'hAA, sel=0 -> out=8'h00 and out_valid=0; first edge after release -> out=8'hAA, out_valid=1.
REQ-027 Select scenario: in0=8'h24, in1=8'h81, sel=0 -> out=8'h24 one cycle later; sel=1 -> out=8'h81 one cycle later.
REQ-028 Unselected input scenario: sel=1, in1=8'h09, in0 toggled 8'h00/8'hFF every cycle -> out stays 8'h09.
REQ-029 Simultaneous change scenario: sel 0->1 and in1 8'h63->8'h0D in the same cycle -> out=8'h0D at the next edge.
REQ-030 Random regression: 10+ random in0/in1 pairs, each checked with sel=0 then sel=1, compared against in0/in1 -> zero mismatches, error count printed.
REQ-031 Combinational scenario: OUT_REG=0, in0=8'h5A, sel=0 -> out=8'h5A within the same time step without any clock edge.

Source files
------------

// File: rtl/mux2x1_pkg.sv
// Shared constants and types for the mux2x1 datapath.
package mux2x1_pkg;

    localparam int unsigned MUX2X1_WIDTH_DEFAULT = 8;

    typedef enum logic {
        SEL_IN0 = 1'b0,
        SEL_IN1 = 1'b1
    } mux2x1_sel_e;

endpackage

// File: rtl/mux2x1_sel.sv
// Combinational WIDTH-bit 2:1 select; any sel value other than 1 picks in0.
module mux2x1_sel
    import mux2x1_pkg::*;
#(
    parameter int unsigned WIDTH = MUX2X1_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = in0_i;
        // Explicit equality keeps an X/Z select on the in0 path
        if (mux2x1_sel_e'(sel_i) == SEL_IN1) begin
            out_o = in1_i;
        end
    end

endmodule

// File: rtl/mux2x1.sv
// 2:1 multiplexer with optional registered output and a post-reset valid flag.
module mux2x1
    import mux2x1_pkg::*;
#(
    parameter int unsigned WIDTH   = MUX2X1_WIDTH_DEFAULT,
    parameter int unsigned OUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_out;

    mux2x1_sel #(
        .WIDTH(WIDTH)
    ) u_sel (
        .in0_i(in0),
        .in1_i(in1),
        .sel_i(sel),
        .out_o(sel_out)
    );

    if (OUT_REG != 0) begin : g_reg
        logic [WIDTH-1:0] out_q, out_d;
        logic             valid_q, valid_d;

        always_comb begin
            out_d   = sel_out;
            valid_d = 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                out_q   <= out_d;
                valid_q <= valid_d;
            end
        end

        assign out       = out_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst};

        assign out       = sel_out;
        assign out_valid = 1'b1;
    end

endmodule

// File: tb/tb_mux2x1.sv
// Randomised and directed bench for mux2x1 in registered and combinational builds.
module tb_mux2x1;

    logic       clk;
    logic       rst;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       sel;
    logic [7:0] out_r;
    logic       valid_r;
    logic [7:0] out_c;
    logic       valid_c;

    int checks = 0;
    int errors = 0;

    // reference model state: expected registered output
    logic [7:0] exp_out;
    logic       exp_valid;
    bit         exp_known = 0;

    mux2x1 #(
        .WIDTH(8),
        .OUT_REG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in0(in0),
        .in1(in1),
        .sel(sel),
        .out(out_r),
        .out_valid(valid_r)
    );

    mux2x1 #(
        .WIDTH(8),
        .OUT_REG(0)
    ) dut_c (
        .clk(clk),
        .rst(rst),
        .in0(in0),
        .in1(in1),
        .sel(sel),
        .out(out_c),
        .out_valid(valid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] choose(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] src [2];
        src[0] = a;
        src[1] = b;
        return src[int'(s)];
    endfunction

    // Drive new inputs mid-cycle; the registered output must not move yet,
    // while the combinational build follows immediately.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic s, input logic r);
        @(negedge clk);
        in0 = a;
        in1 = b;
        sel = s;
        rst = r;
        #1;
        if (exp_known) begin
            chk("hold_out", 64'(out_r), 64'(exp_out));
            chk("hold_valid", 64'(valid_r), 64'(exp_valid));
        end
        chk("comb_out", 64'(out_c), 64'(choose(a, b, s)));
        chk("comb_valid", 64'(valid_c), 64'd1);
    endtask

    task automatic edge_chk(input string tag);
        @(posedge clk);
        if (rst) begin
            exp_out   = 8'h00;
            exp_valid = 1'b0;
        end else begin
            exp_out   = choose(in0, in1, sel);
            exp_valid = 1'b1;
        end
        exp_known = 1;
        #1;
        chk({tag, "_out"}, 64'(out_r), 64'(exp_out));
        chk({tag, "_valid"}, 64'(valid_r), 64'(exp_valid));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst = 1'b1;
        in0 = 8'h00;
        in1 = 8'h00;
        sel = 1'b0;

        // combinational build, no clock edge between drive and check
        apply(8'h5A, 8'h00, 1'b0, 1'b1);
        chk("comb_5A", 64'(out_c), 64'h5A);

        // reset held for two cycles
        apply(8'hAA, 8'h00, 1'b0, 1'b1);
        edge_chk("rst1");
        edge_chk("rst2");
        chk("rst_zero", 64'(out_r), 64'h00);
        apply(8'hAA, 8'h00, 1'b0, 1'b0);
        edge_chk("rel");
        chk("rel_AA", 64'(out_r), 64'hAA);
        chk("rel_valid", 64'(valid_r), 64'd1);

        // basic select
        apply(8'h24, 8'h81, 1'b0, 1'b0);
        edge_chk("sel0");
        chk("sel0_24", 64'(out_r), 64'h24);
        apply(8'h24, 8'h81, 1'b1, 1'b0);
        edge_chk("sel1");
        chk("sel1_81", 64'(out_r), 64'h81);

        // unselected input toggling
        for (int i = 0; i < 6; i++) begin
            apply((i % 2 == 0) ? 8'h00 : 8'hFF, 8'h09, 1'b1, 1'b0);
            edge_chk("unsel");
            chk("unsel_09", 64'(out_r), 64'h09);
        end

        // sel and newly selected input change together
        apply(8'h11, 8'h63, 1'b0, 1'b0);
        edge_chk("simul_a");
        apply(8'h11, 8'h0D, 1'b1, 1'b0);
        edge_chk("simul_b");
        chk("simul_0D", 64'(out_r), 64'h0D);

        // reset mid-operation, with reset priority over selection
        apply(8'h33, 8'h44, 1'b1, 1'b1);
        edge_chk("midrst");
        chk("midrst_zero", 64'(out_r), 64'h00);
        apply(8'h33, 8'h44, 1'b1, 1'b0);
        edge_chk("resume");
        chk("resume_44", 64'(out_r), 64'h44);

        // random pairs, each with sel=0 then sel=1
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            apply(ra, rb, 1'b0, 1'b0);
            edge_chk("rnd0");
            chk("rnd0_in0", 64'(out_r), 64'(ra));
            apply(ra, rb, 1'b1, 1'b0);
            edge_chk("rnd1");
            chk("rnd1_in1", 64'(out_r), 64'(rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
